// File: rtl/conv_seq_ctrl.sv
// Sequencing controller for the convolution engine: walks the 3x3 padded convolution
// (Layer 0) and the 2x2 stride-2 max-pool (Layer 1), emitting addresses and datapath strobes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for ready; counters held at zero
// CONV_RD    | 9 image reads, one per kernel tap (tap_cnt 0..8)
// CONV_DRAIN | no read; last delayed mac_en lands here
// CONV_WR    | write accumulated pixel p into L0
// POOL_RD    | 4 L0 reads of the 2x2 window (rd_cnt 0..3)
// POOL_DRAIN | no read; last delayed pool_en lands here
// POOL_WR    | write pooled value q into L1
// DONE       | one cycle with busy low before returning to IDLE
module conv_seq_ctrl #(
    parameter int IMG_LOG2 = 6,
    localparam int AW = 2 * IMG_LOG2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic [AW-1:0] iaddr,
    output logic          pad,
    output logic [3:0]    tap,
    output logic          mac_en,
    output logic          mac_ld,
    output logic          pool_en,
    output logic          pool_ld,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [2:0]    csel
);

    localparam int QW = AW - 2;
    localparam logic [AW-1:0]       PIX_LAST  = '1;
    localparam logic [AW-1:0]       PIX_ONE   = AW'(1);
    localparam logic [QW-1:0]       POOL_LAST = '1;
    localparam logic [QW-1:0]       POOL_ONE  = QW'(1);
    localparam logic [IMG_LOG2-1:0] EDGE_MAX  = '1;
    localparam logic [IMG_LOG2-1:0] COORD_ONE = IMG_LOG2'(1);
    localparam logic [3:0]          TAP_LAST  = 4'd8;
    localparam logic [2:0]          SEL_NONE  = 3'b000;
    localparam logic [2:0]          SEL_L0    = 3'b001;
    localparam logic [2:0]          SEL_L1    = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        CONV_RD,
        CONV_DRAIN,
        CONV_WR,
        POOL_RD,
        POOL_DRAIN,
        POOL_WR,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] pix;
    logic [QW-1:0] pool_idx;
    logic [3:0]    tap_cnt;
    logic [1:0]    rd_cnt;

    logic          mac_en_q;
    logic [3:0]    tap_q;
    logic          pad_q;
    logic          pool_en_q;
    logic          pool_ld_q;

    logic [IMG_LOG2-1:0] row, col, nb_row, nb_col;
    logic [1:0]          dy, dx;
    logic                row_ok, col_ok, pad_raw;

    assign row = pix[AW-1:IMG_LOG2];
    assign col = pix[IMG_LOG2-1:0];

    // dy/dx encoded as 0 = -1, 1 = 0, 2 = +1
    always_comb begin
        dy     = 2'd1;
        dx     = 2'd1;
        nb_row = row;
        nb_col = col;
        row_ok = 1'b1;
        col_ok = 1'b1;
        case (tap_cnt)
            4'd0, 4'd1, 4'd2: dy = 2'd0;
            4'd3, 4'd4, 4'd5: dy = 2'd1;
            default:          dy = 2'd2;
        endcase
        case (tap_cnt)
            4'd0, 4'd3, 4'd6: dx = 2'd0;
            4'd1, 4'd4, 4'd7: dx = 2'd1;
            default:          dx = 2'd2;
        endcase
        case (dy)
            2'd0: begin
                nb_row = row - COORD_ONE;
                row_ok = (row != '0);
            end
            2'd2: begin
                nb_row = row + COORD_ONE;
                row_ok = (row != EDGE_MAX);
            end
            default: ;
        endcase
        case (dx)
            2'd0: begin
                nb_col = col - COORD_ONE;
                col_ok = (col != '0);
            end
            2'd2: begin
                nb_col = col + COORD_ONE;
                col_ok = (col != EDGE_MAX);
            end
            default: ;
        endcase
        pad_raw = ~(row_ok & col_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pix       <= '0;
            pool_idx  <= '0;
            tap_cnt   <= '0;
            rd_cnt    <= '0;
            mac_en_q  <= 1'b0;
            tap_q     <= '0;
            pad_q     <= 1'b0;
            pool_en_q <= 1'b0;
            pool_ld_q <= 1'b0;
        end else begin
            state <= state_nxt;

            tap_cnt <= (state == CONV_RD && tap_cnt != TAP_LAST) ? tap_cnt + 4'd1 : 4'd0;
            rd_cnt  <= (state == POOL_RD && rd_cnt != 2'd3) ? rd_cnt + 2'd1 : 2'd0;

            case (state)
                IDLE: begin
                    pix      <= '0;
                    pool_idx <= '0;
                end
                CONV_WR: begin
                    if (pix != PIX_LAST) pix <= pix + PIX_ONE;
                    else                 pool_idx <= '0;
                end
                POOL_WR: begin
                    if (pool_idx != POOL_LAST) pool_idx <= pool_idx + POOL_ONE;
                end
                default: ;
            endcase

            // one-cycle delay aligns strobes with the read data returning from memory
            mac_en_q  <= (state == CONV_RD);
            tap_q     <= (state == CONV_RD) ? tap_cnt : 4'd0;
            pad_q     <= (state == CONV_RD) & pad_raw;
            pool_en_q <= (state == POOL_RD);
            pool_ld_q <= (state == POOL_RD) && (rd_cnt == 2'd0);
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        iaddr     = '0;
        crd       = 1'b0;
        caddr_rd  = '0;
        cwr       = 1'b0;
        caddr_wr  = '0;
        csel      = SEL_NONE;
        case (state)
            IDLE: begin
                if (ready) state_nxt = CONV_RD;
            end
            CONV_RD: begin
                busy  = 1'b1;
                iaddr = pad_raw ? '0 : {nb_row, nb_col};
                if (tap_cnt == TAP_LAST) state_nxt = CONV_DRAIN;
            end
            CONV_DRAIN: begin
                busy      = 1'b1;
                state_nxt = CONV_WR;
            end
            CONV_WR: begin
                busy      = 1'b1;
                cwr       = 1'b1;
                csel      = SEL_L0;
                caddr_wr  = pix;
                state_nxt = (pix == PIX_LAST) ? POOL_RD : CONV_RD;
            end
            POOL_RD: begin
                busy     = 1'b1;
                crd      = 1'b1;
                csel     = SEL_L0;
                // window corner 128*qr + 2*qc; rd_cnt bits select +1 and +64
                caddr_rd = {pool_idx[QW-1:IMG_LOG2-1], rd_cnt[1],
                            pool_idx[IMG_LOG2-2:0], rd_cnt[0]};
                if (rd_cnt == 2'd3) state_nxt = POOL_DRAIN;
            end
            POOL_DRAIN: begin
                busy      = 1'b1;
                state_nxt = POOL_WR;
            end
            POOL_WR: begin
                busy      = 1'b1;
                cwr       = 1'b1;
                csel      = SEL_L1;
                caddr_wr  = {2'b00, pool_idx};
                state_nxt = (pool_idx == POOL_LAST) ? DONE : POOL_RD;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pad     = pad_q;
    assign tap     = tap_q;
    assign mac_en  = mac_en_q;
    assign mac_ld  = mac_en_q && (tap_q == 4'd0);
    assign pool_en = pool_en_q;
    assign pool_ld = pool_ld_q;

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Sequencing controller for the 64x64 convolution engine. Generates every address, read/write strobe and datapath control needed to compute Layer 0 and Layer 1:
- Layer 0: 3x3 zero-padded convolution, then bias and ReLU, written to L0 memory.
- Layer 1: 2x2 stride-2 max-pool, read from L0 and written to L1 memory.

The block contains no arithmetic on pixel data. The MAC, bias/ReLU and max-compare datapath sit beside it and act only on the strobes defined here.

## Interface
- IMG_LOG2, 6, log2 of image side. The image is 2^IMG_LOG2 square; AW = 2*IMG_LOG2 is the address width.
- clk  in  1  system clock. One clock only; all logic is rising-edge.
- reset  in  1  asynchronous, active-high. Clears all state and outputs.
- ready  in  1  start request from the host.
- busy  out  1  high while a frame is being processed.
- iaddr  out  AW  image memory read address.
- pad  out  1  delayed with mac_en. When high, the datapath substitutes 0 for idata.
- tap  out  4  kernel index 0..8, delayed with mac_en.
- mac_en / mac_ld  out  1 each  accumulate enable / load instead of accumulate.
- pool_en / pool_ld  out  1 each  max-compare enable / load first operand.
- crd  out  1  layer memory read strobe.
- caddr_rd  out  AW  layer memory read address.
- cwr  out  1  layer memory write strobe.
- caddr_wr  out  AW  layer memory write address.
- csel  out  3  layer select. 001 = L0, 010 = L1, 000 = none.

## Operation
- **States:** IDLE, CONV_RD, CONV_DRAIN, CONV_WR, POOL_RD, POOL_DRAIN, POOL_WR, DONE.
- **IDLE → CONV_RD:** on ready=1 sampled in IDLE. busy goes 1 on the same edge. ready is ignored in every other state.
- **Pixel index:** p = row*64 + col, range 0..4095. Row-major, starting at 0.
- **Tap order:** k = 3*(dy+1) + (dx+1), with dy and dx each in {-1, 0, +1}.
- **CONV_RD (9 cycles, k = 0..8):**
  - If row+dy and col+dx are both in range: iaddr = (row+dy)*64 + (col+dx), pad_raw = 0.
  - Otherwise: iaddr = 0, pad_raw = 1.
- **CONV_DRAIN (1 cycle):** no new address is issued. The final mac_en occurs here.
- **CONV_WR (1 cycle):** cwr = 1, csel = 001, caddr_wr = p.
  - If p < 4095: p increments and the state goes to CONV_RD.
  - If p = 4095: q is set to 0 and the state goes to POOL_RD.
- **Pool index:** q ranges 0..1023, with qr = q >> 5 and qc = q & 31. Base address b = 128*qr + 2*qc.
- **POOL_RD (4 cycles):** crd = 1, csel = 001, caddr_rd = b, b+1, b+64, b+65 in that order.
- **POOL_DRAIN (1 cycle):** no read is issued; the final pool_en occurs here.
- **POOL_WR (1 cycle):** cwr = 1, csel = 010, caddr_wr = q.
  - If q < 1023: q increments and the state goes to POOL_RD.
  - If q = 1023: the state goes to DONE.
- **DONE (1 cycle):** busy = 0, then IDLE. A new frame needs ready sampled in IDLE.
- **Idle values:** in states where they are not driven, iaddr, caddr_rd and caddr_wr are 0, and all strobes are 0.
- **Source of outputs:** every output is decoded from the state, counter and delay registers. There is no combinational path from ready, idata or cdata_rd to any output.
- **Counter widths:** the p, q and tap counters are exactly wide enough for their range. They are cleared on entering their phase and never wrap mid-phase.

## Timing
- **Memory read latency:** image and layer reads have 1-cycle latency. Data for an address issued in cycle n is valid in cycle n+1.
- **Convolution pipeline:**
  - tap, pad and mac_en are the CONV_RD values registered by one cycle.
  - mac_en is high for exactly 9 cycles per pixel: CONV_RD cycles 2..9 and CONV_DRAIN.
  - mac_ld is high together with the first mac_en (tap = 0) only.
- **Pool pipeline:**
  - pool_en is high for 4 cycles per output: POOL_RD cycles 2..4 and POOL_DRAIN.
  - pool_ld is high with the first pool_en only.
- **Write timing:** the accumulator or max value is final at the CONV_WR / POOL_WR edge. The datapath drives cdata_wr combinationally from its registers during that cycle.
- **Frame cycle counts:**
  - 11 cycles per convolution pixel; 6 cycles per pool output.
  - busy is high for exactly 4096*11 + 1024*6 = 51200 cycles.
- **Reset values:** reset=1 at any time, including mid-frame, forces IDLE asynchronously. All outputs go to 0, busy = 0, and all counters and delay registers are cleared. The frame is abandoned and is not resumed.
- **Simultaneous events:** ready=1 in the same cycle that reset falls is not a start. The first start can be sampled on the first edge with reset low.

## Test plan
- **Reset:** assert reset mid-cycle with ready=1 → every output is 0 immediately (asynchronous). After release, busy rises exactly one edge after ready is first sampled.
- **Pixel 0:** iaddr sequence is 0,0,0,0,0,1,0,64,65. pad (delayed one cycle) is 1 for k ∈ {0,1,2,3,6}. mac_ld coincides with tap=0. cwr=1, csel=001, caddr_wr=0 in cycle 11 after busy rises.
- **Pixel 65:** iaddr = 0,1,2,64,65,66,128,129,130, all with pad=0. cwr with caddr_wr=65.
- **Pixel 4095:** pad=1 for k ∈ {2,5,6,7,8}. Pad-free taps read iaddr 4030, 4031, 4094, 4095. The next state is POOL_RD with q=0.
- **Pool q=33:** caddr_rd = 130, 131, 194, 195 with crd=1, csel=001. pool_ld coincides with the first pool_en. Then cwr=1, csel=010, caddr_wr=33.
- **Full frame:** busy is high for 51200 cycles. There are exactly 4096 L0 writes and 1024 L1 writes, with no duplicate addresses. DONE drops busy. Holding ready=1 relaunches one cycle later from IDLE. A reset pulse at cycle 30000 returns to IDLE, and a fresh start repeats the identical sequence from p=0.
